t08_wb_arbiter: RTL and testbench

T08_WB_ARBITER -- requirements
Module: t08_wb_arbiter

---
 rtl/t08_wb_arb_pkg.sv | 33 +++
 rtl/t08_wb_arb_rr.sv | 19 +
 rtl/t08_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_t08_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_wb_arb_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM state, latched request
// fields, and the default abort limit used when T08_WB_ARB_TIMEOUT_EN is defined.
package t08_wb_arb_pkg;

  localparam int T08_TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
  } wb_req_t;

  // Slice one requester's fields out of the flattened per-requester buses.
  function automatic wb_req_t pick_req(input logic        idx,
                                       input logic [1:0]  we,
                                       input logic [63:0] adr,
                                       input logic [63:0] wdat,
                                       input logic [7:0]  sel);
    wb_req_t r;
    r.we   = we[idx];
    r.adr  = adr[{idx, 5'd0} +: 32];
    r.wdat = wdat[{idx, 5'd0} +: 32];
    r.sel  = sel[{idx, 2'd0} +: 4];
    return r;
  endfunction

endpackage

// File: rtl/t08_wb_arb_rr.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module t08_wb_arb_rr (
  input  logic [1:0] req,
  input  logic [1:0] last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/t08_wb_arbiter.sv
// Wishbone classic arbiter: CPU (0) and display/SPI DMA (1) share one SRAM port.
// Define T08_WB_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES bus cycles.
module t08_wb_arbiter
  import t08_wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = T08_TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] adr,
  input  logic [63:0] wdat,
  input  logic [7:0]  sel,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [63:0] rdat,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  arb_state_e  state_q, state_d;
  logic [1:0]  gnt;
  logic [1:0]  last_gnt_q, last_gnt_d;
  logic        cur_q, cur_d;
  wb_req_t     xfer_q, xfer_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [63:0] rdat_q, rdat_d;
  logic        tmo;

  t08_wb_arb_rr u_rr (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

`ifdef T08_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE so it always starts a bus cycle cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else if (!wb_ack_i)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tmo = (state_q == ST_BUS) && !wb_ack_i &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;

  // The limit only matters when the abort counter is built.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_unused
  end
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 2'b10;
      cur_q      <= 1'b0;
      xfer_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cur_q      <= cur_d;
      xfer_q     <= xfer_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req)            state_d = ST_BUS;
      ST_BUS:  if (wb_ack_i || tmo) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Grant/latch on leaving IDLE; completion pulses and read capture on leaving BUS.
  always_comb begin
    last_gnt_d = last_gnt_q;
    cur_d      = cur_q;
    xfer_d     = xfer_q;
    done_d     = '0;
    err_d      = '0;
    rdat_d     = rdat_q;
    if (state_q == ST_IDLE && |req) begin
      last_gnt_d = gnt;
      cur_d      = gnt[1];
      xfer_d     = pick_req(gnt[1], we, adr, wdat, sel);
    end
    if (state_q == ST_BUS && (wb_ack_i || tmo)) begin
      done_d[cur_q] = 1'b1;
      err_d[cur_q]  = tmo;
      if (wb_ack_i && !xfer_q.we) rdat_d[{cur_q, 5'd0} +: 32] = wb_dat_i;
    end
  end

  always_comb begin
    wb_cyc_o = (state_q == ST_BUS);
    wb_stb_o = (state_q == ST_BUS);
    wb_adr_o = xfer_q.adr;
    wb_dat_o = xfer_q.wdat;
    wb_sel_o = xfer_q.sel;
    wb_we_o  = xfer_q.we;
  end

  assign done = done_q;
  assign err  = err_q;
  assign rdat = rdat_q;

endmodule

// File: tb/tb_t08_wb_arbiter.sv
// Directed bench for t08_wb_arbiter with a negedge-driven SRAM responder; the
// no-ack scenario follows T08_WB_ARB_TIMEOUT_EN when that macro is defined.
module tb_t08_wb_arbiter;

  logic        clk;
  logic        nRst;
  logic [1:0]  req, we;
  logic [63:0] adr, wdat;
  logic [7:0]  sel;
  logic [1:0]  done, err;
  logic [63:0] rdat;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;

  logic        ack_en;
  logic        spur;
  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  t08_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .req      (req),
    .we       (we),
    .adr      (adr),
    .wdat     (wdat),
    .sel      (sel),
    .done     (done),
    .err      (err),
    .rdat     (rdat),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM responder: acks one cycle into a bus cycle, or pulses ack on demand.
  initial begin : sram_model
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hA5A5_1234;
    forever begin
      @(negedge clk);
      if (spur) begin
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
      end else if (ack_en && wb_cyc_o && wb_stb_o && !wb_ack_i) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_o[b]) mem[wb_adr_o[9:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
        end else begin
          wb_dat_i = mem[wb_adr_o[9:2]];
        end
      end else begin
        wb_ack_i = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction on requester r and return in its done cycle with req dropped.
  task automatic run_txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    we[r]            = w;
    adr[32*r +: 32]  = a;
    wdat[32*r +: 32] = d;
    sel[4*r +: 4]    = 4'hF;
    req[r]           = 1'b1;
    tick;
    chk("txn_cyc", wb_cyc_o, 1'b1);
    chk("txn_adr", wb_adr_o, a);
    chk("txn_we",  wb_we_o, w);
    if (w) begin
      chk("txn_wdat", wb_dat_o, d);
      chk("txn_sel",  wb_sel_o, 4'hF);
    end
    n = 0;
    while (!done[r] && n < 20) begin
      tick;
      n++;
    end
    chk("txn_done", done[r], 1'b1);
    req[r] = 1'b0;
  endtask

  initial begin : main
    int hi_cnt;
    logic saw_done;
    logic [31:0] exp_adr;

    nRst = 1'b0; req = '0; we = '0; adr = '0; wdat = '0; sel = '0;
    ack_en = 1'b1; spur = 1'b0;
    tick; tick;
    chk("rst_cyc",  wb_cyc_o, 1'b0);
    chk("rst_stb",  wb_stb_o, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_err",  err, 2'b00);
    chk("rst_rdat", rdat, 64'h0);
    chk("rst_adr",  wb_adr_o, 32'h0);
    nRst = 1'b1;
    tick;

    // Single CPU read with exact latency
    adr[31:0] = 32'h3300_0010; sel[3:0] = 4'hF; we[0] = 1'b0; req[0] = 1'b1;
    chk("rd_cyc_pre", wb_cyc_o, 1'b0);
    tick;
    chk("rd_cyc",   wb_cyc_o, 1'b1);
    chk("rd_stb",   wb_stb_o, 1'b1);
    chk("rd_adr",   wb_adr_o, 32'h3300_0010);
    chk("rd_done0", done, 2'b00);
    tick;
    chk("rd_done",  done, 2'b01);
    chk("rd_cyc_lo", wb_cyc_o, 1'b0);
    chk("rd_rdat0", rdat[31:0], 32'hA5A5_1234);
    chk("rd_err",   err, 2'b00);
    req[0] = 1'b0;
    tick;
    chk("rd_done_clr", done, 2'b00);

    // Write then read back via requester 1
    run_txn(1, 1'b1, 32'h3300_0020, 32'hDEAD_BEEF);
    chk("wr_mem",   mem[8], 32'hDEAD_BEEF);
    chk("wr_rdat1", rdat[63:32], 32'h0);
    run_txn(1, 1'b0, 32'h3300_0020, 32'h0);
    chk("rb_rdat1", rdat[63:32], 32'hDEAD_BEEF);
    chk("rb_rdat0", rdat[31:0], 32'hA5A5_1234);
    tick;

    // Spurious ack while idle
    spur = 1'b1;
    tick;
    chk("sp_done", done, 2'b00);
    chk("sp_cyc",  wb_cyc_o, 1'b0);
    chk("sp_rdat", rdat, {32'hDEAD_BEEF, 32'hA5A5_1234});
    spur = 1'b0;
    tick;
    chk("sp_done2", done, 2'b00);
    chk("sp_rdat2", rdat, {32'hDEAD_BEEF, 32'hA5A5_1234});

    // Reset mid-transaction, then requester 1 alone
    ack_en = 1'b0;
    adr[31:0] = 32'h3300_0010; we[0] = 1'b0; req[0] = 1'b1;
    tick;
    chk("mr_cyc_hi", wb_cyc_o, 1'b1);
    nRst = 1'b0;
    #1;
    chk("mr_cyc",  wb_cyc_o, 1'b0);
    chk("mr_stb",  wb_stb_o, 1'b0);
    chk("mr_done", done, 2'b00);
    chk("mr_rdat", rdat, 64'h0);
    chk("mr_adr",  wb_adr_o, 32'h0);
    req = 2'b10; we = 2'b00; adr[63:32] = 32'h3300_0020; sel = 8'hFF;
    tick; tick;
    chk("mr_held_cyc", wb_cyc_o, 1'b0);
    nRst = 1'b1; ack_en = 1'b1;
    tick;
    chk("mr_g1_cyc", wb_cyc_o, 1'b1);
    chk("mr_g1_adr", wb_adr_o, 32'h3300_0020);
    tick;
    chk("mr_g1_done",  done, 2'b10);
    chk("mr_g1_rdat1", rdat[63:32], 32'hDEAD_BEEF);
    req = 2'b00;
    tick;

    // Round robin with both requesters held from reset
    nRst = 1'b0;
    tick;
    nRst = 1'b1;
    adr = {32'h3300_0020, 32'h3300_0010}; we = 2'b00; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_adr = (i % 2 == 1) ? 32'h3300_0020 : 32'h3300_0010;
      tick;
      chk("rr_cyc", wb_cyc_o, 1'b1);
      chk("rr_adr", wb_adr_o, exp_adr);
      tick;
      chk("rr_done", done, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_gap_cyc", wb_cyc_o, 1'b0);
    end
    req = 2'b00;
    tick;
    chk("rr_idle_done", done, 2'b00);
    chk("rr_idle_cyc",  wb_cyc_o, 1'b0);
    chk("rr_rdat", rdat, {32'hDEAD_BEEF, 32'hA5A5_1234});

    // Slave never acks; req dropped mid-bus must not abort
    ack_en = 1'b0;
    adr[31:0] = 32'h3300_0010; we[0] = 1'b0; req = 2'b01;
    tick;
    chk("na_cyc1", wb_cyc_o, 1'b1);
    tick;
    req = 2'b00;
    chk("na_cyc2", wb_cyc_o, 1'b1);
`ifdef T08_WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 6; k++) tick;
    chk("to_cyc8",  wb_cyc_o, 1'b1);
    chk("to_done8", done, 2'b00);
    tick;
    chk("to_cyc_drop", wb_cyc_o, 1'b0);
    chk("to_done", done, 2'b01);
    chk("to_err",  err, 2'b01);
    chk("to_rdat", rdat, {32'hDEAD_BEEF, 32'hA5A5_1234});
    tick;
    chk("to_done_clr", done, 2'b00);
    chk("to_err_clr",  err, 2'b00);
`else
    hi_cnt = 0;
    saw_done = 1'b0;
    for (int k = 0; k < 98; k++) begin
      tick;
      if (wb_cyc_o) hi_cnt++;
      if (done != 2'b00) saw_done = 1'b1;
    end
    chk("nt_hi_cnt",   hi_cnt, 98);
    chk("nt_cyc100",   wb_cyc_o, 1'b1);
    chk("nt_saw_done", saw_done, 1'b0);
    ack_en = 1'b1;
    tick;
    chk("nt_done",  done, 2'b01);
    chk("nt_err",   err, 2'b00);
    chk("nt_rdat0", rdat[31:0], 32'hA5A5_1234);
    tick;
    chk("nt_done_clr", done, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
